// File: rtl/claa_seq_pkg.sv
// Shared types and constants for the byte-serial CLAA sequencer.
// Optional subtract mode is enabled by defining CLAA_SEQ_SUB_EN.
package claa_seq_pkg;

  localparam int CLAA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/claa.sv
// 8-bit carry-lookahead adder slice.
// Every carry is built from generate/propagate terms, not rippled.
module claa
  import claa_seq_pkg::*;
(
  output logic [CLAA_W-1:0] R,
  output logic              C_out,
  input  logic [CLAA_W-1:0] A,
  input  logic [CLAA_W-1:0] B,
  input  logic              C_in
);

  logic [CLAA_W-1:0] g;
  logic [CLAA_W-1:0] p;
  logic [CLAA_W:0]   c;
  logic              pp;

  assign g = A & B;
  assign p = A ^ B;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]C_in
  always_comb begin
    c    = '0;
    pp   = 1'b0;
    c[0] = C_in;
    for (int i = 0; i < CLAA_W; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & C_in);
    end
  end

  assign R     = p ^ c[CLAA_W-1:0];
  assign C_out = c[CLAA_W];

endmodule

// File: rtl/claa_seq_ctrl.sv
// Byte-serial wide adder: one shared claa slice, carry chained in a register.
// Define CLAA_SEQ_SUB_EN to add the sub port (a - b mode).
module claa_seq_ctrl
  import claa_seq_pkg::*;
#(
  parameter  int NBYTES = 4,
  localparam int W      = CLAA_W * NBYTES,
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef CLAA_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out
);

  state_t state;
  state_t state_nxt;

  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic              carry;
  logic [IW-1:0]     idx;
  logic              last;
  logic [CLAA_W-1:0] slice_a;
  logic [CLAA_W-1:0] slice_b;
  logic [CLAA_W-1:0] slice_r;
  logic              slice_c;
  logic [W-1:0]      b_in;
  logic              cin0;

`ifdef CLAA_SEQ_SUB_EN
  assign b_in = sub ? ~b : b;
  assign cin0 = sub;
`else
  assign b_in = b;
  assign cin0 = 1'b0;
`endif

  assign slice_a = a_reg[CLAA_W*idx +: CLAA_W];
  assign slice_b = b_reg[CLAA_W*idx +: CLAA_W];
  assign last    = (idx == IW'(NBYTES - 1));

  claa u_claa (
    .R     (slice_r),
    .C_out (slice_c),
    .A     (slice_a),
    .B     (slice_b),
    .C_in  (carry)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b_in;
            carry <= cin0;
            idx   <= '0;
          end
        end
        S_RUN: begin
          sum[CLAA_W*idx +: CLAA_W] <= slice_r;
          carry <= slice_c;
          if (last) begin
            c_out <= slice_c;
            idx   <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
